// File: rtl/rob_pkg.sv
// Shared types for the ROB sequence-number allocator.
//   rob_alloc_state_e : allocator FSM state (RUN / DRAIN)
package rob_pkg;

   typedef enum logic [0:0] {
      ROB_ALLOC_RUN   = 1'b0,
      ROB_ALLOC_DRAIN = 1'b1
   } rob_alloc_state_e;

endpackage

// File: rtl/rob_wrap_ctr.sv
// Modulo-p_depth pointer with increment enable and synchronous reset.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, clears ptr to 0
//   inc  : advance ptr by one (wraps p_depth-1 -> 0)
//   ptr  : current pointer value
module rob_wrap_ctr #(
   parameter int p_depth    = 32,
   parameter int p_ptrwidth = $clog2(p_depth)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inc,
   output logic [p_ptrwidth-1:0] ptr
);

   localparam logic [p_ptrwidth-1:0] c_last = p_ptrwidth'(p_depth - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == c_last) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/rob_sn_alloc.sv
// Sequence-number allocator on the ROB issue side. Grants in-order slot
// indices, tracks outstanding entries against ROB front dequeues, and
// offers a drain handshake for flushes.
//
// Optional feature macro: ROB_SN_ALLOC_BYPASS_EN
//   defined     : a commit in the same cycle lets a full allocator grant
//   not defined : full blocks every grant (no cmt_en -> alloc_cpl path)
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   alloc_en    : allocation request
//   alloc_cpl   : allocation granted this cycle
//   alloc_sn    : granted sequence number (current allocation pointer)
//   cmt_en      : ROB front dequeued one entry
//   drain_req   : stop granting until all outstanding entries commit
//   drain_done  : one-cycle pulse when the drain completes
//   count       : outstanding entries
//   full, empty : count == p_depth / count == 0
//   err         : sticky, commit seen while empty
//
// State table:
//   state           | meaning
//   ROB_ALLOC_RUN   | normal operation, grants allowed
//   ROB_ALLOC_DRAIN | grants blocked, waiting for count == 0
module rob_sn_alloc
   import rob_pkg::*;
#(
   parameter int p_depth    = 32,
   parameter int p_ptrwidth = $clog2(p_depth)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_en,
   output logic                  alloc_cpl,
   output logic [p_ptrwidth-1:0] alloc_sn,
   input  logic                  cmt_en,
   input  logic                  drain_req,
   output logic                  drain_done,
   output logic [p_ptrwidth:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  err
);

   localparam logic [p_ptrwidth:0] c_depth = (p_ptrwidth + 1)'(p_depth);

   rob_alloc_state_e state_q, state_d;
   logic [p_ptrwidth-1:0] alloc_ptr, cmt_ptr, ptr_diff;
   logic [p_ptrwidth:0]   count_q;
   logic                  cmt_fire, alloc_ok, err_q;

   rob_wrap_ctr #(.p_depth(p_depth), .p_ptrwidth(p_ptrwidth)) u_alloc_ptr (
      .clk (clk),
      .rst (rst),
      .inc (alloc_cpl),
      .ptr (alloc_ptr)
   );

   rob_wrap_ctr #(.p_depth(p_depth), .p_ptrwidth(p_ptrwidth)) u_cmt_ptr (
      .clk (clk),
      .rst (rst),
      .inc (cmt_fire),
      .ptr (cmt_ptr)
   );

   assign full     = (count_q == c_depth);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign err      = err_q;
   assign alloc_sn = alloc_ptr;
   assign cmt_fire = cmt_en && !empty;

`ifdef ROB_SN_ALLOC_BYPASS_EN
   assign alloc_ok = !full || cmt_fire;
`else
   assign alloc_ok = !full;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ROB_ALLOC_RUN;
      else     state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ROB_ALLOC_RUN:   if (drain_req)       state_d = ROB_ALLOC_DRAIN;
         ROB_ALLOC_DRAIN: if (count_q == '0)   state_d = ROB_ALLOC_RUN;
         default:                              state_d = ROB_ALLOC_RUN;
      endcase
   end

   // outputs; rst gates both so nothing leaks out while reset is held
   always_comb begin
      alloc_cpl  = 1'b0;
      drain_done = 1'b0;
      if (!rst) begin
         alloc_cpl  = alloc_en && alloc_ok && (state_q == ROB_ALLOC_RUN);
         drain_done = (state_q == ROB_ALLOC_DRAIN) && (count_q == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case ({alloc_cpl, cmt_fire})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (cmt_en && empty) err_q <= 1'b1;
      end
   end

   // pointer distance must always match the outstanding count
   assign ptr_diff = alloc_ptr - cmt_ptr;

   a_ptr_count: assert property (@(posedge clk) disable iff (rst)
      ptr_diff == count_q[p_ptrwidth-1:0]);

endmodule
